// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer beside the ID-stage decoder: takes illegal-opcode and
// synchronised interrupt requests, flushes, redirects to the kernel vector and returns.
module exc_ctrl #(
  parameter logic [31:0] ILLOP_VEC   = 32'h8000_0004,
  parameter logic [31:0] IRQ_VEC     = 32'h8000_0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Irq,
  input  logic        ID_Valid,
  input  logic        ID_Stall,
  input  logic [31:0] ID_PC,
  input  logic        ID_BadOp,
  input  logic        ID_KRet,
  input  logic        EX_BranchTaken,
  output logic        ExcFlush,
  output logic        ExcRedirect,
  output logic [31:0] ExcPC,
  output logic        EpcWrite,
  output logic [31:0] Epc,
  output logic [1:0]  Cause,
  output logic        KernelMode,
  output logic        IrqAck
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_TAKE   = 2'd1,
    ST_KERNEL = 2'd2,
    ST_RET    = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_IRQ   = 2'b01;
  localparam logic [1:0] CAUSE_ILLOP = 2'b10;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irq_prev_q;
  logic                   irq_pend_q;
  logic                   flush_q;
  logic                   redirect_q;
  logic [31:0]            exc_pc_q;
  logic                   epc_write_q;
  logic [31:0]            epc_q;
  logic [1:0]             cause_q;
  logic                   kernel_q;
  logic                   irq_ack_q;

  logic irq_rise;
  logic acc;
  logic kret_ok;

  assign irq_rise = sync_q[SYNC_STAGES-1] & ~irq_prev_q;

  // Kernel code (PC[31]=1) is never interrupted; a squashed or stalled ID slot defers.
  assign acc     = (state_q == ST_RUN) & ID_Valid & ~ID_Stall & ~EX_BranchTaken & ~ID_PC[31];
  assign kret_ok = ID_Valid & ID_KRet & ~ID_Stall & ~EX_BranchTaken;

  // NOTE: non-blocking assignments here so each flop of the chain samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      irq_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], Irq};
      irq_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edges while already pending merge; the request is consumed only by its own TAKE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend_q <= 1'b0;
    end else if (state_q == ST_TAKE && cause_q == CAUSE_IRQ) begin
      irq_pend_q <= 1'b0;
    end else if (irq_rise) begin
      irq_pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      exc_pc_q    <= '0;
      epc_write_q <= 1'b0;
      epc_q       <= '0;
      cause_q     <= CAUSE_NONE;
      kernel_q    <= 1'b0;
      irq_ack_q   <= 1'b0;
    end else begin
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      exc_pc_q    <= '0;
      epc_write_q <= 1'b0;
      irq_ack_q   <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (acc && (ID_BadOp || irq_pend_q)) begin
            state_q     <= ST_TAKE;
            flush_q     <= 1'b1;
            redirect_q  <= 1'b1;
            epc_write_q <= 1'b1;
            kernel_q    <= 1'b1;
            if (ID_BadOp) begin
              cause_q  <= CAUSE_ILLOP;
              epc_q    <= ID_PC + 32'd4;
              exc_pc_q <= ILLOP_VEC;
            end else begin
              cause_q   <= CAUSE_IRQ;
              epc_q     <= ID_PC;
              exc_pc_q  <= IRQ_VEC;
              irq_ack_q <= 1'b1;
            end
          end
        end
        ST_TAKE: begin
          state_q <= ST_KERNEL;
        end
        ST_KERNEL: begin
          if (kret_ok) begin
            state_q    <= ST_RET;
            flush_q    <= 1'b1;
            redirect_q <= 1'b1;
            exc_pc_q   <= epc_q;
          end
        end
        ST_RET: begin
          state_q  <= ST_RUN;
          kernel_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_RUN;
          kernel_q <= 1'b0;
        end
      endcase
    end
  end

  assign ExcFlush    = flush_q;
  assign ExcRedirect = redirect_q;
  assign ExcPC       = exc_pc_q;
  assign EpcWrite    = epc_write_q;
  assign Epc         = epc_q;
  assign Cause       = cause_q;
  assign KernelMode  = kernel_q;
  assign IrqAck      = irq_ack_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: a flag-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_exc_ctrl;

  localparam int          S     = 2;
  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] IRQV  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Irq, ID_Valid, ID_Stall, ID_BadOp, ID_KRet, EX_BranchTaken;
  logic [31:0] ID_PC;
  logic        ExcFlush, ExcRedirect, EpcWrite, KernelMode, IrqAck;
  logic [31:0] ExcPC, Epc;
  logic [1:0]  Cause;

  int checks   = 0;
  int failures = 0;

  exc_ctrl #(.ILLOP_VEC(ILLOP), .IRQ_VEC(IRQV), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .Irq(Irq), .ID_Valid(ID_Valid), .ID_Stall(ID_Stall),
    .ID_PC(ID_PC), .ID_BadOp(ID_BadOp), .ID_KRet(ID_KRet), .EX_BranchTaken(EX_BranchTaken),
    .ExcFlush(ExcFlush), .ExcRedirect(ExcRedirect), .ExcPC(ExcPC), .EpcWrite(EpcWrite),
    .Epc(Epc), .Cause(Cause), .KernelMode(KernelMode), .IrqAck(IrqAck)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: in_entry / in_kernel / in_return flags mark where the exception sequence is.
  bit          m_entry, m_kern, m_ret, m_pend;
  logic [1:0]  m_cause;
  logic [31:0] m_epc;
  logic [S:0]  m_hist;
  bit          running, accept, kret, rising, nx_entry;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_entry = 0; m_kern = 0; m_ret = 0; m_pend = 0;
      m_cause = 2'b00; m_epc = 32'h0; m_hist = '0;
    end else begin
      running  = !(m_entry || m_kern || m_ret);
      accept   = running && ID_Valid && !ID_Stall && !EX_BranchTaken && !ID_PC[31];
      kret     = m_kern && ID_Valid && ID_KRet && !ID_Stall && !EX_BranchTaken;
      rising   = m_hist[S-1] && !m_hist[S];
      nx_entry = accept && (ID_BadOp || m_pend);
      if (m_entry && m_cause == 2'b01) m_pend = 0;
      else if (rising)                  m_pend = 1;
      if (nx_entry) begin
        if (ID_BadOp) begin m_cause = 2'b10; m_epc = ID_PC + 32'd4; end
        else          begin m_cause = 2'b01; m_epc = ID_PC;         end
      end
      m_kern  = m_entry || (m_kern && !kret);
      m_ret   = kret;
      m_entry = nx_entry;
      m_hist  = {m_hist[S-1:0], Irq};
    end
  end

  function automatic logic [71:0] model_vec();
    logic        fl;
    logic [31:0] pc;
    fl = m_entry || m_ret;
    pc = m_entry ? ((m_cause == 2'b10) ? ILLOP : IRQV) : (m_ret ? m_epc : 32'h0);
    return {1'b0, fl, fl, pc, m_entry, m_epc, m_cause, m_entry || m_kern || m_ret,
            m_entry && (m_cause == 2'b01)};
  endfunction

  function automatic logic [71:0] dut_vec();
    return {1'b0, ExcFlush, ExcRedirect, ExcPC, EpcWrite, Epc, Cause, KernelMode, IrqAck};
  endfunction

  always @(negedge clk) begin
    if (rst_n) check("cycle_outputs", dut_vec(), model_vec());
  end

  task automatic exp_out(input string name, input logic fl, input logic [31:0] pc,
                         input logic ew, input logic [31:0] epc, input logic [1:0] cause,
                         input logic km, input logic ack);
    check(name, dut_vec(), {1'b0, fl, fl, pc, ew, epc, cause, km, ack});
  endtask

  task automatic cyc(input logic v, input logic st, input logic [31:0] pc,
                     input logic bad, input logic kr, input logic br);
    ID_Valid = v; ID_Stall = st; ID_PC = pc; ID_BadOp = bad; ID_KRet = kr; EX_BranchTaken = br;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ret_seq();
    cyc(1'b1, 1'b0, 32'h8000_0300, 1'b0, 1'b1, 1'b0);
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rnd, rpc;
    int n, acks;
    rst_n = 1'b0; Irq = 1'b0;
    ID_Valid = 0; ID_Stall = 0; ID_PC = 32'h0; ID_BadOp = 0; ID_KRet = 0; EX_BranchTaken = 0;
    repeat (2) @(negedge clk);
    exp_out("reset_state", 0, 32'h0, 0, 32'h0, 2'b00, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      rnd = $urandom; rpc = $urandom;
      cyc(rnd[0], rnd[1], rpc, 1'b0, rnd[2], rnd[3]);
    end
    exp_out("idle_after_traffic", 0, 32'h0, 0, 32'h0, 2'b00, 0, 0);

    // Illegal opcode entry and return
    cyc(1, 0, 32'h0040_0010, 1, 0, 0);
    exp_out("take_illop", 1, 32'h8000_0004, 1, 32'h0040_0014, 2'b10, 1, 0);
    cyc(1, 0, 32'h0040_0018, 1, 0, 0);
    exp_out("kernel_after_take", 0, 32'h0, 0, 32'h0040_0014, 2'b10, 1, 0);
    cyc(1, 0, 32'h0040_0018, 1, 0, 0);
    exp_out("kernel_ignores_badop", 0, 32'h0, 0, 32'h0040_0014, 2'b10, 1, 0);
    cyc(1, 0, 32'h8000_0180, 0, 1, 0);
    exp_out("ret_illop", 1, 32'h0040_0014, 0, 32'h0040_0014, 2'b10, 1, 0);
    cyc(1, 0, 32'h0040_0014, 0, 0, 0);
    exp_out("run_after_ret", 0, 32'h0, 0, 32'h0040_0014, 2'b10, 0, 0);

    // Interrupt latency
    Irq = 1'b1; n = 0;
    do begin
      cyc(1, 0, 32'h0040_0020, 0, 0, 0);
      n++;
    end while (IrqAck !== 1'b1 && n < 10);
    check("irq_ack_within_bound", {71'b0, (IrqAck === 1'b1 && n <= S + 2)}, 72'd1);
    exp_out("take_irq", 1, 32'h8000_0008, 1, 32'h0040_0020, 2'b01, 1, 1);
    idle(1);
    exp_out("kernel_irq", 0, 32'h0, 0, 32'h0040_0020, 2'b01, 1, 0);
    cyc(1, 0, 32'h8000_0100, 0, 1, 0);
    exp_out("ret_irq", 1, 32'h0040_0020, 0, 32'h0040_0020, 2'b01, 1, 0);
    Irq = 1'b0;
    idle(4);

    // Two edges while pending give a single acknowledge
    Irq = 1'b1; repeat (3) cyc(1, 1, 32'h0040_0030, 0, 0, 0);
    Irq = 1'b0; repeat (3) cyc(1, 1, 32'h0040_0030, 0, 0, 0);
    Irq = 1'b1; repeat (4) cyc(1, 1, 32'h0040_0030, 0, 0, 0);
    acks = 0;
    repeat (8) begin
      cyc(1, 0, 32'h0040_0030, 0, 0, 0);
      if (IrqAck === 1'b1) acks++;
    end
    check("single_ack_merged", 72'(acks), 72'd1);
    ret_seq();
    acks = 0;
    repeat (6) begin
      cyc(1, 0, 32'h0040_0034, 0, 0, 0);
      if (IrqAck === 1'b1) acks++;
    end
    check("no_ack_after_merged_return", 72'(acks), 72'd0);
    Irq = 1'b0;
    idle(4);

    // Irq arriving in kernel is taken on the first accept after return
    cyc(1, 0, 32'h0040_0040, 1, 0, 0);
    exp_out("take_illop2", 1, ILLOP, 1, 32'h0040_0044, 2'b10, 1, 0);
    Irq = 1'b1; idle(3);
    Irq = 1'b0; idle(3);
    exp_out("kernel_irq_pending_no_take", 0, 32'h0, 0, 32'h0040_0044, 2'b10, 1, 0);
    cyc(1, 0, 32'h8000_0200, 0, 1, 0);
    exp_out("ret_to_epc", 1, 32'h0040_0044, 0, 32'h0040_0044, 2'b10, 1, 0);
    cyc(1, 0, 32'h0040_0044, 0, 0, 0);
    exp_out("run_first_after_ret", 0, 32'h0, 0, 32'h0040_0044, 2'b10, 0, 0);
    cyc(1, 0, 32'h0040_0044, 0, 0, 0);
    exp_out("take_irq_after_ret", 1, IRQV, 1, 32'h0040_0044, 2'b01, 1, 1);
    idle(1);
    ret_seq();

    // BadOp beats a pending irq; the irq follows the return
    Irq = 1'b1; repeat (4) cyc(1, 1, 32'h0040_0050, 1, 0, 0);
    Irq = 1'b0;
    cyc(1, 0, 32'h0040_0050, 1, 0, 0);
    exp_out("badop_beats_irq", 1, ILLOP, 1, 32'h0040_0054, 2'b10, 1, 0);
    idle(1);
    ret_seq();
    cyc(1, 0, 32'h0040_0054, 0, 0, 0);
    exp_out("irq_after_badop_return", 1, IRQV, 1, 32'h0040_0054, 2'b01, 1, 1);
    idle(1);
    ret_seq();

    // Deferral and suppression cases
    cyc(1, 0, 32'h0040_0060, 1, 0, 1);
    exp_out("branch_defers", 0, 32'h0, 0, 32'h0040_0054, 2'b01, 0, 0);
    cyc(1, 1, 32'h0040_0060, 1, 0, 0);
    exp_out("stall_defers", 0, 32'h0, 0, 32'h0040_0054, 2'b01, 0, 0);
    cyc(1, 0, 32'h8000_0060, 1, 0, 0);
    exp_out("kernel_pc_no_take", 0, 32'h0, 0, 32'h0040_0054, 2'b01, 0, 0);
    cyc(0, 0, 32'h0040_0060, 1, 0, 0);
    exp_out("bubble_no_take", 0, 32'h0, 0, 32'h0040_0054, 2'b01, 0, 0);

    // Reset during TAKE drops everything, including the pending irq
    Irq = 1'b1; repeat (4) cyc(1, 1, 32'h0040_0070, 0, 0, 0);
    Irq = 1'b0;
    cyc(1, 0, 32'h0040_0070, 1, 0, 0);
    exp_out("take_before_reset", 1, ILLOP, 1, 32'h0040_0074, 2'b10, 1, 0);
    #1 rst_n = 1'b0;
    #1 exp_out("reset_in_take", 0, 32'h0, 0, 32'h0, 2'b00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      cyc(1, 0, 32'h0040_0080, 0, 0, 0);
      if (IrqAck === 1'b1 || ExcRedirect === 1'b1) acks++;
    end
    check("no_event_after_reset", 72'(acks), 72'd0);
    exp_out("run_after_reset", 0, 32'h0, 0, 32'h0, 2'b00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt sequencer for the 5-stage MIPS pipeline. It sits beside the ID-stage decoder and takes illegal-opcode flags (BadOp) and an external interrupt line. It sequences the flush, the redirect to the kernel vector, EPC capture and the return to user code. Its redirect and flush outputs have priority over the decoder's PCSrc/CtrlFlush.

Parameters:
ILLOP_VEC, 32'h80000004, redirect target for an illegal opcode
IRQ_VEC, 32'h80000008, redirect target for an interrupt
SYNC_STAGES, 2, synchroniser depth on Irq (≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Irq  in  1  external interrupt, asynchronous level; a rising edge is one request
ID_Valid  in  1  ID holds a real instruction (not a bubble)
ID_Stall  in  1  hazard unit stalling IF/ID this cycle
ID_PC  in  32  PC of instruction in ID
ID_BadOp  in  1  decoder BadOp for ID instruction
ID_KRet  in  1  ID instruction is the kernel-return (jr $k0 decoded in kernel)
EX_BranchTaken  in  1  branch resolved taken in EX; ID instruction will be squashed
ExcFlush  out  1  flush IF/ID and ID/EX
ExcRedirect  out  1  PC mux selects ExcPC (overrides PCSrc)
ExcPC  out  32  redirect target
EpcWrite  out  1  one-cycle pulse: datapath writes Epc to $k0 (r26)
Epc  out  32  saved return address
Cause  out  2  00 none, 01 irq, 10 illegal opcode; held until next exception
KernelMode  out  1  1 from exception entry until return completes
IrqAck  out  1  one-cycle pulse when an interrupt is taken

Behaviour:
- Reset (async, rst_n=0): state RUN. All outputs 0. Epc=0, Cause=00, sync chain=0, pending=0.
- Irq path: SYNC_STAGES-flop synchroniser, then rising-edge detect sets irq_pend. irq_pend clears only in the TAKE cycle when Cause=01. An edge arriving while irq_pend=1 is merged (no counting).
- Accept condition: acc = state==RUN & ID_Valid & !ID_Stall & !EX_BranchTaken & !ID_PC[31].
- States:
  - RUN:
    - acc & ID_BadOp → TAKE. Latch Cause=10 and Epc=ID_PC+4 (skip the bad instruction).
    - Else acc & irq_pend → TAKE. Latch Cause=01 and Epc=ID_PC (ID instruction is re-executed).
    - BadOp has priority over irq; an irq that loses to BadOp stays pending.
    - Otherwise stay in RUN; all outputs 0 except Epc and Cause, which hold.
  - TAKE (exactly 1 cycle):
    - ExcFlush=1, ExcRedirect=1, EpcWrite=1.
    - ExcPC=ILLOP_VEC if Cause=10, else IRQ_VEC. IrqAck=1 iff Cause=01.
    - KernelMode=1 from this cycle on. → KERNEL.
  - KERNEL:
    - KernelMode=1. BadOp and irq are not accepted; irq edges still set irq_pend.
    - ID_Valid & ID_KRet & !ID_Stall & !EX_BranchTaken → RET.
  - RET (1 cycle): ExcFlush=1, ExcRedirect=1, ExcPC=Epc, KernelMode=1. → RUN; KernelMode=0 from the next cycle.
- Latency: the exception is detected in ID in cycle N. Flush and redirect occur in cycle N+1, so the vector instruction is fetched in N+2.
- Epc and Cause change only on the RUN→TAKE transition.
- ExcPC=0 in every state except TAKE and RET.
- Redirect outputs are registered (driven from state), not combinational from inputs.
- Return with irq pending: the irq can be accepted on the first acc cycle in RUN after RET. That is the earliest the returned-to instruction reaches ID.
- ID_Stall or EX_BranchTaken during a candidate cycle defers the decision; it is re-evaluated on each following cycle.
- ID_PC[31]=1 (kernel code) in RUN: exceptions are never taken; the decoder already suppresses BadOp there.
- Reset asserted in any state: immediate return to RUN. The pending irq is lost, and no spurious IrqAck or redirect follows deassertion.

Test Plan:
- Reset release, Irq=0, random ID traffic for 20 cycles → all outputs 0, state RUN.
- ID_PC=0x00400010, ID_BadOp=1, ID_Valid=1 → next cycle ExcRedirect=1, ExcPC=0x80000004, Epc=0x00400014, Cause=10, EpcWrite=1, IrqAck=0; KernelMode=1 thereafter.
- Irq rises at cycle 5, ID_PC=0x00400020 valid, no stall → IrqAck within SYNC_STAGES+2 cycles, ExcPC=0x80000008, Epc=0x00400020, Cause=01. A second Irq edge while pending → only one IrqAck.
- In KERNEL, pulse Irq, then ID_KRet=1 → RET cycle ExcPC=Epc. The irq is taken on the first acc cycle after RET, with Epc equal to the returned-to PC.
- BadOp together with pending irq in the same cycle → Cause=10, Epc=PC+4. The irq is taken only after the return.
- EX_BranchTaken=1 or ID_Stall=1 coincident with BadOp → no TAKE that cycle. rst_n pulsed low during TAKE → outputs 0 immediately, state RUN, irq_pend cleared.
